seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Parametrised Avalon-MM slave driving a multiplexed N-digit 7-segment display and debouncing M active-low push-buttons.
- Successor to the fixed 6-digit/4-button display component; adds configurable digit and button counts, a hex-decode or raw-segment mode, anti-ghost blanking, and button edge capture.
- Instantiated in the Qsys system; conduits go to the board display and button pins.

Parameters:
- N_DIGITS, 6, number of digits scanned (1..8).
- N_BUTTONS, 4, number of buttons (1..8).
- SCAN_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off.
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised input must be stable before the debounced state changes.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  4  word address.
- write  in  1  write strobe.
- writedata  in  32  write data.
- read  in  1  read strobe.
- readdata  out  32  read data, valid 1 cycle after read.
- selseg  out  8  segment drive, active-high: bit0=a … bit6=g, bit7=dp.
- nseldig  out  N_DIGITS  digit select, active-low one-hot.
- nbutton  in  N_BUTTONS  raw buttons, active-low, asynchronous.
- ledbutton  out  N_BUTTONS  debounced pressed state, 1 = pressed.

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - selseg=0, nseldig=all 1, ledbutton=0, readdata=0.
  - CTRL=0x1, HEX=0, DP=0, RAW[i]=0, EDGE=0, digit index=0, prescaler=0.
- Register map:
  - 0 CTRL: bit0 enable, bit1 raw mode.
  - 1 HEX: 4 bits per digit, digit i in bits [4i+3:4i].
  - 2 DP: bit i = decimal point of digit i.
  - 3 BTN: read-only debounced state.
  - 4 EDGE: write-1-to-clear.
  - 8+i RAW[i]: 8-bit segment pattern for digit i, for i<N_DIGITS.
  - Unmapped addresses read 0; writes to them are ignored.
- Reads: readdata is registered with a latency of 1. Reads have no side effects.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. On wrap, the digit index increments and wraps from N_DIGITS-1 to 0.
  - While prescaler < BLANK_CYCLES, or enable=0: nseldig is all 1 and selseg=0.
  - Otherwise: nseldig bit[index]=0; selseg = decode(HEX nibble index) with dp from DP[index], or RAW[index] when raw=1.
  - Outputs are registered, so they lag the prescaler/index by 1 cycle.
- Decode table, values 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- A register write takes effect from the next displayed slot cycle. There is no tearing within one digit beyond that 1-cycle register latency.
- Debounce, per button:
  - 2-FF synchroniser, then invert so 1 = pressed.
  - Counter resets whenever the synchronised value equals the debounced state.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state takes the new value.
  - Total press latency = 2 sync cycles + DEBOUNCE_CYCLES cycles.
- Edge capture: EDGE[j] sets on a 0→1 transition of debounced[j]. A write of 1 to a bit clears it. If a set and a clear occur in the same cycle, set wins.
- ledbutton mirrors the debounced state.
- A reset asserted mid-scan or mid-debounce returns everything to its reset values immediately. No partial state is retained.

Optional Feature:
- Macro: SEG7_SCAN_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and register 5 IRQMASK (N_BUTTONS bits, reset 0).
  - irq is registered: irq = |(EDGE & IRQMASK). It deasserts the cycle after the W1C clear takes effect.
- Undefined:
  - No irq port.
  - Address 5 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then run 3×SCAN_DIV cycles with SCAN_DIV=8, BLANK_CYCLES=2 -> in each slot, nseldig is all 1 for 2 cycles, then digit 0,1,2 is low in turn; selseg=0x3F throughout the active part of each slot.
- Write HEX=0x00A5_4321, DP=0x02 -> digits 0..5 show 06, DB (5B|dp), 4F, 66, 6D, 77; index wraps from 5 to 0.
- Write CTRL=0x3, RAW[2]=0x80 -> digit 2 drives 0x80. Write CTRL=0x0 -> nseldig all 1 and selseg=0 from the next cycle.
- DEBOUNCE_CYCLES=16: bounce nbutton[1] every 5 cycles for 40 cycles, then hold it low -> BTN bit1 rises exactly 2+16 cycles after the last transition; EDGE=0x2. Write 4←0x2 -> EDGE=0.
- Issue a press edge and a W1C write of the same bit in the same cycle -> EDGE bit stays 1.
- SEG7_SCAN_IRQ_EN defined, IRQMASK=0x1, press button 0 -> irq=1 one cycle after EDGE sets; W1C clears EDGE, and irq falls on the following cycle.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Avalon-MM register bus between the host and the 7-segment scan controller.
interface seg7_scan_ctrl_if;
    logic [3:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scanner with M debounced push-buttons and edge capture.
// Define SEG7_SCAN_IRQ_EN to add the irq output and the IRQMASK register at address 5.
module seg7_scan_ctrl #(
    parameter int unsigned N_DIGITS        = 6,
    parameter int unsigned N_BUTTONS       = 4,
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned BLANK_CYCLES    = 500,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seg7_scan_ctrl_if.slave      avs,
    output logic [7:0]           selseg,
    output logic [N_DIGITS-1:0]  nseldig,
    input  logic [N_BUTTONS-1:0] nbutton,
    output logic [N_BUTTONS-1:0] ledbutton
`ifdef SEG7_SCAN_IRQ_EN
    ,
    output logic                 irq
`endif
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic                  enable_q, raw_mode_q;
    logic [4*N_DIGITS-1:0] hex_q;
    logic [N_DIGITS-1:0]   dp_q;
    logic [7:0]            raw_q [N_DIGITS];
    logic [N_BUTTONS-1:0]  edge_q, edge_d;
    logic [PRE_W-1:0]      prescaler_q, prescaler_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [7:0]            selseg_q, selseg_d;
    logic [N_DIGITS-1:0]   nseldig_q, nseldig_d;
    logic [31:0]           readdata_q, readdata_d;
    logic [N_BUTTONS-1:0]  sync1_q, sync2_q;
    logic [N_BUTTONS-1:0]  deb_q, deb_d;
    logic [DEB_W-1:0]      cnt_q [N_BUTTONS];
    logic [DEB_W-1:0]      cnt_d [N_BUTTONS];
`ifdef SEG7_SCAN_IRQ_EN
    logic [N_BUTTONS-1:0]  irqmask_q;
    logic                  irq_q;
`endif

    logic wr_ctrl, wr_hex, wr_dp, wr_edge, wr_raw, raw_addr_ok;
    logic unused_wdata;

    assign unused_wdata = ^avs.writedata;
    assign raw_addr_ok  = avs.address[3] && (32'(avs.address[2:0]) < N_DIGITS);
    assign wr_ctrl      = avs.write && (avs.address == 4'd0);
    assign wr_hex       = avs.write && (avs.address == 4'd1);
    assign wr_dp        = avs.write && (avs.address == 4'd2);
    assign wr_edge      = avs.write && (avs.address == 4'd4);
    assign wr_raw       = avs.write && raw_addr_ok;

    // Scan timing and the next segment/digit drive; blanking hides ghosting on digit change.
    always_comb begin
        logic [3:0] nib;
        logic       blank;
        prescaler_d = prescaler_q + PRE_W'(1);
        index_d     = index_q;
        if (prescaler_q == PRE_W'(SCAN_DIV - 1)) begin
            prescaler_d = '0;
            index_d     = (index_q == IDX_W'(N_DIGITS - 1)) ? '0 : index_q + IDX_W'(1);
        end
        blank     = !enable_q || (prescaler_q < PRE_W'(BLANK_CYCLES));
        nib       = hex_q[{index_q, 2'b00} +: 4];
        selseg_d  = raw_mode_q ? raw_q[index_q] : {dp_q[index_q], hex2seg(nib)};
        nseldig_d = ~(N_DIGITS'(1) << index_q);
        if (blank) begin
            selseg_d  = '0;
            nseldig_d = '1;
        end
    end

    // Per-button debounce counter and edge capture; a same-cycle set beats the clear.
    always_comb begin
        logic [N_BUTTONS-1:0] pressed;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        pressed = ~sync2_q;
        for (int unsigned j = 0; j < N_BUTTONS; j++) begin
            if (pressed[j] == deb_q[j]) begin
                cnt_d[j] = '0;
            end else if (cnt_q[j] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[j] = pressed[j];
                cnt_d[j] = '0;
            end else begin
                cnt_d[j] = cnt_q[j] + DEB_W'(1);
            end
        end
        edge_d = (edge_q & ~(wr_edge ? avs.writedata[N_BUTTONS-1:0] : '0)) | (deb_d & ~deb_q);
    end

    always_comb begin
        readdata_d = '0;
        case (avs.address)
            4'd0: readdata_d = {30'b0, raw_mode_q, enable_q};
            4'd1: readdata_d = 32'(hex_q);
            4'd2: readdata_d = 32'(dp_q);
            4'd3: readdata_d = 32'(deb_q);
            4'd4: readdata_d = 32'(edge_q);
`ifdef SEG7_SCAN_IRQ_EN
            4'd5: readdata_d = 32'(irqmask_q);
`endif
            default: begin
                if (raw_addr_ok) readdata_d = {24'b0, raw_q[avs.address[2:0]]};
            end
        endcase
        if (!avs.read) readdata_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q    <= 1'b1;
            raw_mode_q  <= 1'b0;
            hex_q       <= '0;
            dp_q        <= '0;
            for (int unsigned i = 0; i < N_DIGITS; i++) raw_q[i] <= '0;
            edge_q      <= '0;
            prescaler_q <= '0;
            index_q     <= '0;
            selseg_q    <= '0;
            nseldig_q   <= '1;
            readdata_q  <= '0;
            sync1_q     <= '1;
            sync2_q     <= '1;
            deb_q       <= '0;
            for (int unsigned j = 0; j < N_BUTTONS; j++) cnt_q[j] <= '0;
`ifdef SEG7_SCAN_IRQ_EN
            irqmask_q   <= '0;
            irq_q       <= 1'b0;
`endif
        end else begin
            if (wr_ctrl) begin
                enable_q   <= avs.writedata[0];
                raw_mode_q <= avs.writedata[1];
            end
            if (wr_hex) hex_q <= avs.writedata[4*N_DIGITS-1:0];
            if (wr_dp)  dp_q  <= avs.writedata[N_DIGITS-1:0];
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                if (wr_raw && (avs.address[2:0] == 3'(i))) raw_q[i] <= avs.writedata[7:0];
            end
            edge_q      <= edge_d;
            prescaler_q <= prescaler_d;
            index_q     <= index_d;
            selseg_q    <= selseg_d;
            nseldig_q   <= nseldig_d;
            readdata_q  <= readdata_d;
            sync1_q     <= nbutton;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
`ifdef SEG7_SCAN_IRQ_EN
            if (avs.write && (avs.address == 4'd5)) irqmask_q <= avs.writedata[N_BUTTONS-1:0];
            irq_q <= |(edge_q & irqmask_q);
`endif
        end
    end

    assign selseg       = selseg_q;
    assign nseldig      = nseldig_q;
    assign ledbutton    = deb_q;
    assign avs.readdata = readdata_q;
`ifdef SEG7_SCAN_IRQ_EN
    assign irq          = irq_q;
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: register vector table, cycle model of the scanned display,
// debounce/edge/irq hand sequences, and asynchronous reset mid-run.
module tb_seg7_scan_ctrl;
    localparam int ND = 6;
    localparam int NB = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if bus();
    logic [7:0]    selseg;
    logic [ND-1:0] nseldig;
    logic [NB-1:0] nbutton;
    logic [NB-1:0] ledbutton;
`ifdef SEG7_SCAN_IRQ_EN
    logic irq;
`endif

    seg7_scan_ctrl #(
        .N_DIGITS(ND), .N_BUTTONS(NB), .SCAN_DIV(SD),
        .BLANK_CYCLES(BC), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avs(bus),
        .selseg(selseg),
        .nseldig(nseldig),
        .nbutton(nbutton),
        .ledbutton(ledbutton)
`ifdef SEG7_SCAN_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] dec_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Display model: shadow registers plus a cycle count since reset release.
    logic          sh_en, sh_raw;
    logic [31:0]   sh_hex;
    logic [7:0]    sh_dp;
    logic [7:0]    sh_rawv [ND];
    int            ecnt;
    logic [7:0]    exp_seg;
    logic [ND-1:0] exp_dig;
    bit            disp_chk = 1'b0;

    always @(posedge clk) begin
        int p;
        int idx;
        if (!reset_n) begin
            ecnt = 0; sh_en = 1'b1; sh_raw = 1'b0; sh_hex = '0; sh_dp = '0;
            for (int i = 0; i < ND; i++) sh_rawv[i] = '0;
            exp_seg = '0; exp_dig = '1;
        end else begin
            p   = ecnt % SD;
            idx = (ecnt / SD) % ND;
            if (!sh_en || p < BC) begin
                exp_seg = '0; exp_dig = '1;
            end else begin
                exp_dig      = '1;
                exp_dig[idx] = 1'b0;
                exp_seg = sh_raw ? sh_rawv[idx]
                                 : (dec_tab[sh_hex[4*idx +: 4]] | (sh_dp[idx] ? 8'h80 : 8'h00));
            end
            ecnt++;
            if (bus.write) begin
                case (bus.address)
                    4'd0: begin sh_en = bus.writedata[0]; sh_raw = bus.writedata[1]; end
                    4'd1: sh_hex = bus.writedata;
                    4'd2: sh_dp = bus.writedata[7:0];
                    default: if (bus.address >= 4'd8 && int'(bus.address) < 8 + ND)
                                 sh_rawv[int'(bus.address) - 8] = bus.writedata[7:0];
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (disp_chk) begin
            if (!reset_n) begin
                check("selseg_rst", 32'(selseg), 32'h0);
                check("nseldig_rst", 32'(nseldig), 32'(6'h3F));
            end else begin
                check("selseg", 32'(selseg), 32'(exp_seg));
                check("nseldig", 32'(nseldig), 32'(exp_dig));
            end
        end
    end

    // Read scoreboard: expected value queued at issue, compared when readdata is valid.
    logic        rd_d1 = 1'b0;
    logic [31:0] rd_q [$];
    always @(posedge clk) rd_d1 <= bus.read;
    always @(negedge clk) begin
        if (rd_d1) begin
            if (rd_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd_scoreboard: readdata 0x%0h with no expected entry", bus.readdata);
            end else begin
                check("readdata", bus.readdata, rd_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(posedge clk); #1;
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        rd_q.push_back(e);
        bus.read = 1'b1; bus.address = a;
        @(posedge clk); #1;
        bus.read = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct packed {
        logic        is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back({1'b0, 4'd0,  32'h1});
        vecs.push_back({1'b0, 4'd1,  32'h0});
        vecs.push_back({1'b0, 4'd3,  32'h0});
        vecs.push_back({1'b0, 4'd4,  32'h0});
        vecs.push_back({1'b1, 4'd1,  32'hFFFF_FFFF});
        vecs.push_back({1'b0, 4'd1,  32'h00FF_FFFF});
        vecs.push_back({1'b1, 4'd1,  32'h00A5_4321});
        vecs.push_back({1'b1, 4'd2,  32'hFF});
        vecs.push_back({1'b0, 4'd2,  32'h3F});
        vecs.push_back({1'b1, 4'd2,  32'h02});
        vecs.push_back({1'b0, 4'd1,  32'h00A5_4321});
        vecs.push_back({1'b0, 4'd2,  32'h02});
        vecs.push_back({1'b1, 4'd6,  32'hDEAD});
        vecs.push_back({1'b0, 4'd6,  32'h0});
        vecs.push_back({1'b1, 4'd15, 32'h55});
        vecs.push_back({1'b0, 4'd15, 32'h0});
        vecs.push_back({1'b1, 4'd10, 32'h80});
        vecs.push_back({1'b0, 4'd10, 32'h80});
        vecs.push_back({1'b1, 4'd8,  32'h1FF});
        vecs.push_back({1'b0, 4'd8,  32'hFF});
        vecs.push_back({1'b1, 4'd3,  32'hF});
        vecs.push_back({1'b0, 4'd3,  32'h0});
`ifndef SEG7_SCAN_IRQ_EN
        vecs.push_back({1'b1, 4'd5,  32'hF});
        vecs.push_back({1'b0, 4'd5,  32'h0});
`endif

        bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writedata = '0;
        nbutton = '1;
        #1 reset_n = 1'b0;
        disp_chk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_selseg", 32'(selseg), 32'h0);
        check("rst_nseldig", 32'(nseldig), 32'(6'h3F));
        check("rst_ledbutton", 32'(ledbutton), 32'h0);
        check("rst_readdata", bus.readdata, 32'h0);
`ifdef SEG7_SCAN_IRQ_EN
        check("rst_irq", 32'(irq), 32'h0);
`endif
        reset_n = 1'b1;

        // Default display (all digits "0") across a full digit-index wrap.
        cycles(7 * SD);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
            else               rd(vecs[i].addr, vecs[i].data);
        end
        cycles(7 * SD);

        wr(4'd0, 32'h3);
        cycles(6 * SD);
        wr(4'd0, 32'h0);
        cycles(2 * SD);
        wr(4'd0, 32'h1);
        rd(4'd0, 32'h1);

        // Bounce button 1, then hold it pressed; debounced state rises 2+DB edges later.
        for (int k = 0; k < 8; k++) begin
            nbutton[1] = ~nbutton[1];
            cycles(5);
            check("bounce_led", 32'(ledbutton), 32'h0);
        end
        nbutton[1] = 1'b0;
        for (int e = 1; e <= 2 + DB; e++) begin
            @(posedge clk); @(negedge clk);
            check("press_led", 32'(ledbutton), (e >= 2 + DB) ? 32'h2 : 32'h0);
        end
        @(posedge clk); #1;
        rd(4'd3, 32'h2);
        rd(4'd4, 32'h2);
        wr(4'd4, 32'h2);
        rd(4'd4, 32'h0);
        nbutton[1] = 1'b1;
        cycles(DB + 4);
        check("release_led", 32'(ledbutton), 32'h0);
        rd(4'd4, 32'h0);
        rd(4'd3, 32'h0);

        // Press edge and W1C of the same bit in the same cycle: set wins.
        nbutton[0] = 1'b0;
        cycles(DB + 1);
        wr(4'd4, 32'h1);
        check("collide_led", 32'(ledbutton), 32'h1);
        rd(4'd4, 32'h1);
        wr(4'd4, 32'h1);
        rd(4'd4, 32'h0);

`ifdef SEG7_SCAN_IRQ_EN
        wr(4'd5, 32'h1);
        rd(4'd5, 32'h1);
        nbutton[0] = 1'b1;
        cycles(DB + 4);
        check("irq_idle", 32'(irq), 32'h0);
        nbutton[0] = 1'b0;
        cycles(DB + 1);
        @(posedge clk); @(negedge clk);
        check("irq_at_edge_set", 32'(irq), 32'h0);
        @(posedge clk); @(negedge clk);
        check("irq_after_edge", 32'(irq), 32'h1);
        @(posedge clk); #1;
        wr(4'd4, 32'h1);
        check("irq_clear_cycle", 32'(irq), 32'h1);
        cycles(1);
        check("irq_cleared", 32'(irq), 32'h0);
        rd(4'd4, 32'h0);
`endif

        // Asynchronous reset in the middle of a slot and of a debounce.
        nbutton = 4'b1011;
        cycles(DB + 4);
        check("btn2_led", 32'(ledbutton), 32'h4);
        wr(4'd0, 32'h3);
        wr(4'd1, 32'h0012_3456);
        wr(4'd11, 32'h5A);
        nbutton[0] = 1'b0;
        cycles(SD + 3);
        reset_n = 1'b0;
        #1;
        check("midrst_selseg", 32'(selseg), 32'h0);
        check("midrst_nseldig", 32'(nseldig), 32'(6'h3F));
        check("midrst_led", 32'(ledbutton), 32'h0);
        nbutton = '1;
        cycles(3);
        reset_n = 1'b1;
        rd(4'd0, 32'h1);
        rd(4'd1, 32'h0);
        rd(4'd3, 32'h0);
        rd(4'd4, 32'h0);
        rd(4'd11, 32'h0);
        cycles(3 * SD);

        n_vec++;
        if (rd_q.size() != 0) begin
            n_err++;
            $display("FAIL rd_drain: %0d reads never answered, want 0", rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
